fetch_sequencer: RTL and testbench

Controller for the fetch-stage PC register. Each cycle it decides whether the PC register loads and which next-PC it loads. It merges hazard stalls, a multi-cycle mult/div busy window, control-flow redirects (which may need to be held while the pipe is stalled) and a halt request. It sits between the hazard/branch logic and the fetch unit, driving the fetch unit's `npc` and `en` inputs.

---
 rtl/fetch_pkg.sv | 10 +
 rtl/fetch_sequencer_if.sv | 23 ++
 rtl/md_stall_counter.sv | 14 +
 rtl/fetch_sequencer.sv | 60 ++++++
 tb/tb_fetch_sequencer.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared defaults, word size and state encoding for the fetch sequencer
package fetch_pkg;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam int ROM_WORDS_DEFAULT = 4096;
    localparam int WORD_BYTES = 4;
    localparam logic [1:0] FS_RUN = 2'd0;
    localparam logic [1:0] FS_STALL = 2'd1;
    localparam logic [1:0] FS_HALT = 2'd2;
    typedef enum logic [1:0] {RUN = FS_RUN, STALL = FS_STALL, HALT = FS_HALT} fs_state_t;
endpackage

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: request inputs and fetch-control outputs of the fetch sequencer
interface fetch_sequencer_if;
    logic [31:0] pc;
    logic stall_req;
    logic redir_valid;
    logic [31:0] redir_target;
    logic md_start;
    logic [3:0] md_cycles;
    logic halt_req;
    logic [31:0] npc;
    logic en;
    logic redir_taken;
    logic halted;
    logic fault;
    modport master (
        output pc, stall_req, redir_valid, redir_target, md_start, md_cycles, halt_req,
        input npc, en, redir_taken, halted, fault
    );
    modport slave (
        input pc, stall_req, redir_valid, redir_target, md_start, md_cycles, halt_req,
        output npc, en, redir_taken, halted, fault
    );
endinterface

// File: rtl/md_stall_counter.sv
// md_stall_counter: mult/div busy window, reloaded on start and counting down to zero
module md_stall_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] cycles,
    output logic       busy
);
    logic [3:0] cnt;
    assign busy = cnt != 4'd0;
    always_ff @(posedge clk or negedge reset)
        if (!reset) cnt <= 4'd0;
        else cnt <= start ? cycles : cnt - {3'd0, busy};
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC load control merging stalls, mult/div busy, redirects and halt; FETCH_SEQ_BOUND_CHECK_EN adds the ROM bound check
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int ROM_WORDS = ROM_WORDS_DEFAULT
) (
    input logic clk,
    input logic reset,
    fetch_sequencer_if.slave bus
);
`ifdef FETCH_SEQ_BOUND_CHECK_EN
    localparam logic CHECK = 1'b1;
`else
    localparam logic CHECK = 1'b0;
`endif
    localparam logic [32:0] LO = {1'b0, RESET_PC};
    localparam logic [32:0] HI = LO + 33'(WORD_BYTES * ROM_WORDS);
    fs_state_t state;
    logic busy, stall_cond, halt_now, go, bad, pend_v;
    logic [31:0] pend_t, target;
    md_stall_counter u_md (
        .clk(clk),
        .reset(reset),
        .start(bus.md_start),
        .cycles(bus.md_cycles),
        .busy(busy)
    );
    assign stall_cond = bus.stall_req | busy;
    assign halt_now = (state == HALT) | bus.halt_req;
    assign go = reset & !halt_now & !stall_cond;
    assign target = bus.redir_valid ? bus.redir_target : pend_v ? pend_t : bus.pc + 32'(WORD_BYTES);
    // a candidate load outside the ROM window or misaligned is refused and halts fetch
    assign bad = CHECK & go & (({1'b0, target} < LO) | ({1'b0, target} >= HI) | (target[1:0] != 2'b00));
    assign bus.en = go & !bad;
    assign bus.npc = !reset ? RESET_PC : go ? target : bus.pc;
    assign bus.redir_taken = bus.en & (bus.redir_valid | pend_v);
    assign bus.halted = state == HALT;
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state <= RUN;
            pend_v <= 1'b0;
            pend_t <= 32'd0;
        end else begin
            state <= (halt_now | bad) ? HALT : stall_cond ? STALL : RUN;
            if (halt_now | bad) pend_v <= 1'b0;
            else if (bus.redir_valid & !bus.en) pend_v <= 1'b1;
            else if (bus.en) pend_v <= 1'b0;
            if (bus.redir_valid & !bus.en) pend_t <= bus.redir_target;
        end
`ifdef FETCH_SEQ_BOUND_CHECK_EN
    logic fault_q;
    always_ff @(posedge clk or negedge reset)
        if (!reset) fault_q <= 1'b0;
        else fault_q <= fault_q | bad;
    assign bus.fault = fault_q;
`else
    assign bus.fault = 1'b0;
`endif
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: vector table, directed corner cases and random run against a cycle-level reference model
module tb_fetch_sequencer;
    localparam logic [31:0] RPC = 32'h0000_3000;
    localparam int RW = 4096;
    typedef struct {
        logic st, rv;
        logic [31:0] tgt;
        logic ms;
        logic [3:0] mc;
        logic hr, en;
        logic [31:0] npc;
        logic tk, hl;
    } vec_t;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int errors = 0, checks = 0;
    int cyc = 0, busy_until = 0;
    logic m_halt = 1'b0, m_fault = 1'b0;
    logic [31:0] pend_q[$];
    vec_t tab[19];
    always #5 clk = ~clk;
    fetch_sequencer_if bus();
    fetch_sequencer #(.RESET_PC(RPC), .ROM_WORDS(RW)) dut (.clk(clk), .reset(reset), .bus(bus));

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, got, exp);
        end
    endtask

    task automatic drive(input logic st, input logic rv, input logic [31:0] tgt,
                         input logic ms, input logic [3:0] mc, input logic hr);
        bus.stall_req = st;
        bus.redir_valid = rv;
        bus.redir_target = tgt;
        bus.md_start = ms;
        bus.md_cycles = mc;
        bus.halt_req = hr;
    endtask

    // what a correct sequencer does this cycle, from the rules themselves
    task automatic predict(output logic e_en, output logic [31:0] e_npc, output logic e_tk, output logic e_bad);
        logic cand, has;
        cand = !(m_halt || bus.halt_req) && !(bus.stall_req || cyc <= busy_until);
        has = bus.redir_valid || pend_q.size() > 0;
        e_npc = bus.redir_valid ? bus.redir_target : pend_q.size() > 0 ? pend_q[0] : bus.pc + 32'd4;
        e_bad = 1'b0;
`ifdef FETCH_SEQ_BOUND_CHECK_EN
        e_bad = cand && (e_npc < RPC || e_npc >= RPC + 32'(4 * RW) || e_npc[1:0] != 2'b00);
`endif
        e_en = cand && !e_bad;
        e_tk = e_en && has;
    endtask

    task automatic check_model(input string tag);
        logic e_en, e_tk, e_bad;
        logic [31:0] e_npc;
        predict(e_en, e_npc, e_tk, e_bad);
        if (!reset) begin
            chk({tag, ".rst_en"}, bus.en, 0);
            chk({tag, ".rst_npc"}, bus.npc, RPC);
            chk({tag, ".rst_tk"}, bus.redir_taken, 0);
            chk({tag, ".rst_halted"}, bus.halted, 0);
            chk({tag, ".rst_fault"}, bus.fault, 0);
        end else begin
            chk({tag, ".en"}, bus.en, e_en);
            if (e_en) chk({tag, ".npc"}, bus.npc, e_npc);
            chk({tag, ".tk"}, bus.redir_taken, e_tk);
            chk({tag, ".halted"}, bus.halted, m_halt);
            chk({tag, ".fault"}, bus.fault, m_fault);
        end
    endtask

    // clock edge: advance the reference model and the modelled fetch unit's PC
    task automatic finish_cycle();
        logic e_en, e_tk, e_bad;
        logic [31:0] e_npc;
        predict(e_en, e_npc, e_tk, e_bad);
        @(posedge clk);
        if (!reset) begin
            m_halt = 1'b0;
            m_fault = 1'b0;
            pend_q.delete();
            busy_until = cyc;
            bus.pc = RPC;
        end else begin
            if (m_halt || bus.halt_req || e_bad) begin
                m_halt = 1'b1;
                pend_q.delete();
            end else if (bus.redir_valid && !e_en) begin
                pend_q.delete();
                pend_q.push_back(bus.redir_target);
            end else if (e_en) pend_q.delete();
            if (e_bad) m_fault = 1'b1;
            if (bus.md_start) busy_until = cyc + int'(bus.md_cycles);
            if (e_en) bus.pc = e_npc;
        end
        cyc++;
        #1;
    endtask

    task automatic cycle(input string tag);
        @(negedge clk);
        check_model(tag);
        finish_cycle();
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        cycle(tag);
        cycle(tag);
        reset = 1'b1;
    endtask

    initial begin
        tab[0]  = '{0, 0, 32'h0,    0, 0, 0, 1, 32'h3004, 0, 0};
        tab[1]  = '{0, 0, 32'h0,    0, 0, 0, 1, 32'h3004, 0, 0};
        tab[2]  = '{0, 0, 32'h0,    1, 3, 0, 1, 32'h3004, 0, 0};
        tab[3]  = '{0, 0, 32'h0,    0, 0, 0, 0, 32'h0,    0, 0};
        tab[4]  = '{0, 0, 32'h0,    0, 0, 0, 0, 32'h0,    0, 0};
        tab[5]  = '{0, 0, 32'h0,    0, 0, 0, 0, 32'h0,    0, 0};
        tab[6]  = '{0, 0, 32'h0,    0, 0, 0, 1, 32'h3004, 0, 0};
        tab[7]  = '{1, 1, 32'h3100, 0, 0, 0, 0, 32'h0,    0, 0};
        tab[8]  = '{1, 0, 32'h0,    0, 0, 0, 0, 32'h0,    0, 0};
        tab[9]  = '{0, 0, 32'h0,    0, 0, 0, 1, 32'h3100, 1, 0};
        tab[10] = '{0, 0, 32'h0,    0, 0, 0, 1, 32'h3004, 0, 0};
        tab[11] = '{1, 1, 32'h3100, 0, 0, 0, 0, 32'h0,    0, 0};
        tab[12] = '{1, 1, 32'h3200, 0, 0, 0, 0, 32'h0,    0, 0};
        tab[13] = '{0, 0, 32'h0,    0, 0, 0, 1, 32'h3200, 1, 0};
        tab[14] = '{0, 0, 32'h0,    0, 0, 0, 1, 32'h3004, 0, 0};
        tab[15] = '{1, 1, 32'h3300, 0, 0, 0, 0, 32'h0,    0, 0};
        tab[16] = '{0, 0, 32'h0,    0, 0, 1, 0, 32'h0,    0, 0};
        tab[17] = '{0, 0, 32'h0,    0, 0, 0, 0, 32'h0,    0, 1};
        tab[18] = '{0, 1, 32'h3400, 0, 0, 0, 0, 32'h0,    0, 1};
        bus.pc = RPC;
        drive(0, 0, 0, 0, 0, 0);
        #1;
        do_reset("reset");
        for (int i = 0; i < 19; i++) begin
            bus.pc = RPC;
            drive(tab[i].st, tab[i].rv, tab[i].tgt, tab[i].ms, tab[i].mc, tab[i].hr);
            @(negedge clk);
            chk($sformatf("tab%0d.en", i), bus.en, tab[i].en);
            if (tab[i].en) chk($sformatf("tab%0d.npc", i), bus.npc, tab[i].npc);
            chk($sformatf("tab%0d.tk", i), bus.redir_taken, tab[i].tk);
            chk($sformatf("tab%0d.halted", i), bus.halted, tab[i].hl);
            finish_cycle();
        end
        do_reset("unhalt");
        bus.pc = RPC;
        drive(0, 0, 0, 1, 0, 0);
        cycle("md0_start");
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("md0.en", bus.en, 1);
        finish_cycle();
        drive(0, 0, 0, 1, 15, 0);
        cycle("md15_start");
        drive(1, 1, 32'h3500, 0, 0, 0);
        cycle("md15_pend");
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        cycle("midreset");
        reset = 1'b1;
        bus.pc = 32'h3010;
        @(negedge clk);
        chk("postreset.en", bus.en, 1);
        chk("postreset.npc", bus.npc, 32'h3014);
        chk("postreset.tk", bus.redir_taken, 0);
        finish_cycle();
        drive(0, 1, 32'h3102, 0, 0, 0);
        cycle("misaligned");
        drive(0, 0, 0, 0, 0, 0);
        bus.pc = 32'hFFFF_FFFC;
        @(negedge clk);
`ifdef FETCH_SEQ_BOUND_CHECK_EN
        chk("wrap.en", bus.en, 0);
`else
        chk("wrap.en", bus.en, 1);
        chk("wrap.npc", bus.npc, 32'h0);
`endif
        finish_cycle();
        do_reset("rst2");
`ifdef FETCH_SEQ_BOUND_CHECK_EN
        drive(0, 1, 32'h7000, 0, 0, 0);
        @(negedge clk);
        chk("bound.en", bus.en, 0);
        chk("bound.tk", bus.redir_taken, 0);
        finish_cycle();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("bound.fault", bus.fault, 1);
        chk("bound.halted", bus.halted, 1);
        finish_cycle();
        do_reset("rst3");
`endif
        for (int i = 0; i < 800; i++) begin
            reset = !((m_halt && $urandom_range(0, 7) == 0) || $urandom_range(0, 199) == 0);
            drive($urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 15) == 0 ? $urandom : RPC + 32'(4 * $urandom_range(0, RW - 1)),
                  $urandom_range(0, 11) == 0, 4'($urandom_range(0, 15)), $urandom_range(0, 149) == 0);
            cycle("rand");
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
